// File: rtl/sim_run_pkg.sv
// Shared types and helpers for the simulation run-control monitor.
package sim_run_pkg;

   // Run-control state, encoded as it appears on the state output.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } run_state_t;

   // Termination cause, encoded as it appears on the reason output.
   typedef enum logic [2:0] {
      RSN_NONE     = 3'd0,
      RSN_FAIL_REQ = 3'd1,
      RSN_TIMEOUT  = 3'd2,
      RSN_HANG     = 3'd3,
      RSN_PASS     = 3'd4
   } run_reason_t;

   // Number of set bits in a commit strobe vector (up to eight channels).
   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/sim_run_history.sv
// Commit-history ring: records {channel, pc} of every retired instruction
// while enabled; newest record is read at hist_idx == 0.
// Built only when SIM_RUN_MONITOR_HISTORY_EN is defined.
module sim_run_history #(
   parameter int NCH        = 2,
   parameter int XLEN       = 64,
   parameter int HIST_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [NCH-1:0]                commit_valid,
   input  logic [NCH*XLEN-1:0]           commit_pc,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [XLEN-1:0]               hist_pc,
   output logic [2:0]                    hist_ch
);

   localparam int IW = $clog2(HIST_DEPTH);

   typedef struct packed {
      logic [2:0]      ch;
      logic [XLEN-1:0] pc;
   } hist_rec_t;

   hist_rec_t     ring_q [HIST_DEPTH];
   logic [IW-1:0] wptr_q;
   logic [IW-1:0] wr_addr [NCH];
   logic [IW-1:0] acc;
   logic [IW-1:0] rd_addr;

   // Slot for each valid channel: lower channels take earlier (older) slots.
   always_comb begin
      acc = '0;
      for (int i = 0; i < NCH; i++) begin
         wr_addr[i] = wptr_q + acc;
         acc        = acc + IW'(commit_valid[i]);
      end
   end

   // Ring storage and write pointer; pointer wraps naturally modulo depth.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr_q <= '0;
         // NOTE: the ring is cleared on reset because unwritten entries must
         // read as zero; a plain data memory would normally be left unreset.
         for (int i = 0; i < HIST_DEPTH; i++) begin
            ring_q[i] <= '0;
         end
      end else if (wr_en) begin
         wptr_q <= wptr_q + acc;
         for (int i = 0; i < NCH; i++) begin
            if (commit_valid[i]) begin
               ring_q[wr_addr[i]] <= '{ch: 3'(i), pc: commit_pc[i*XLEN +: XLEN]};
            end
         end
      end
   end

   // Newest-first read: index 0 is the slot just behind the write pointer.
   assign rd_addr = wptr_q - IW'(1) - hist_idx;
   assign hist_pc = ring_q[rd_addr].pc;
   assign hist_ch = ring_q[rd_addr].ch;

endmodule

// File: rtl/sim_run_monitor.sv
// Run-control monitor for the simulation harness: cycle/commit counters,
// pass/fail/timeout/hang termination and a cycle-windowed dump enable.
// Optional commit-history ring enabled by defining SIM_RUN_MONITOR_HISTORY_EN.
module sim_run_monitor
   import sim_run_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int XLEN       = 64,
   parameter int HIST_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NCH-1:0]                commit_valid,
   input  logic [NCH*XLEN-1:0]           commit_pc,
   input  logic                          finish_req,
   input  logic                          fail_req,
   input  logic [63:0]                   max_cycles,
   input  logic [31:0]                   hang_limit,
   input  logic [63:0]                   dump_start,
   input  logic [63:0]                   dump_len,
   output logic [1:0]                    state,
   output logic [2:0]                    reason,
   output logic [63:0]                   cycle_count,
   output logic [63:0]                   commit_total,
   output logic                          dump_en,
   output logic                          done
`ifdef SIM_RUN_MONITOR_HISTORY_EN
   ,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [XLEN-1:0]               hist_pc,
   output logic [2:0]                    hist_ch
`endif
);

   run_state_t  state_q, state_d;
   run_reason_t reason_q, reason_d;
   logic [63:0] cyc_q, cyc_d;
   logic [63:0] tot_q, tot_d;
   logic [31:0] hang_q, hang_d;
   logic        dump_q, dump_d;

   logic [63:0] cyc_inc;
   logic [64:0] tot_sum;
   logic [63:0] tot_add;
   logic [31:0] hang_nxt;
   logic        timeout_hit;
   logic        hang_hit;
   logic [64:0] dump_end;

   // Saturating next values used in every RUN cycle.
   assign cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + 64'd1;
   assign tot_sum     = {1'b0, tot_q} + 65'(popcount(8'(commit_valid)));
   assign tot_add     = tot_sum[64] ? '1 : tot_sum[63:0];
   assign hang_nxt    = (|commit_valid) ? '0 : ((hang_q == '1) ? hang_q : hang_q + 32'd1);
   assign timeout_hit = (max_cycles != '0) && (cyc_q > max_cycles);
   assign hang_hit    = (hang_limit != '0) && (hang_nxt == hang_limit);
   assign dump_end    = {1'b0, dump_start} + {1'b0, dump_len};

   // Next-state, counter updates and termination arbitration.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      reason_d = reason_q;
      cyc_d    = cyc_q;
      tot_d    = tot_q;
      hang_d   = hang_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_RUN;
            cyc_d   = 64'd1;
         end
         ST_RUN: begin
            cyc_d  = cyc_inc;
            tot_d  = tot_add;
            hang_d = hang_nxt;
            if (fail_req) begin
               state_d  = ST_FAIL;
               reason_d = RSN_FAIL_REQ;
            end else if (timeout_hit) begin
               state_d  = ST_FAIL;
               reason_d = RSN_TIMEOUT;
            end else if (hang_hit) begin
               state_d  = ST_FAIL;
               reason_d = RSN_HANG;
            end else if (finish_req) begin
               state_d  = ST_PASS;
               reason_d = RSN_PASS;
            end
         end
         default: ;  // PASS/FAIL hold everything until reset
      endcase
      dump_d = (state_d == ST_RUN) && (cyc_d >= dump_start) &&
               ((dump_len == '0) || ({1'b0, cyc_d} < dump_end));
   end

   // State, counter and dump-enable registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so update order inside this block does not matter.
      if (!reset) begin
         state_q  <= ST_IDLE;
         reason_q <= RSN_NONE;
         cyc_q    <= '0;
         tot_q    <= '0;
         hang_q   <= '0;
         dump_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         cyc_q    <= cyc_d;
         tot_q    <= tot_d;
         hang_q   <= hang_d;
         dump_q   <= dump_d;
      end
   end

   assign state        = state_q;
   assign reason       = reason_q;
   assign cycle_count  = cyc_q;
   assign commit_total = tot_q;
   assign dump_en      = dump_q;
   assign done         = (state_q == ST_PASS) || (state_q == ST_FAIL);

`ifdef SIM_RUN_MONITOR_HISTORY_EN
   sim_run_history #(
      .NCH        (NCH),
      .XLEN       (XLEN),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_history (
      .clock        (clock),
      .reset        (reset),
      .wr_en        (state_q == ST_RUN),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .hist_idx     (hist_idx),
      .hist_pc      (hist_pc),
      .hist_ch      (hist_ch)
   );
`else
   // PCs and ring depth only matter when the history ring is built.
   logic unused_hist_cfg;
   assign unused_hist_cfg = ^{commit_pc, 32'(HIST_DEPTH)};
`endif

endmodule

// File: tb/tb_sim_run_monitor.sv
// Scoreboard bench for sim_run_monitor: stimulus pushes expected records,
// a monitor process compares them when the DUT presents them.
module tb_sim_run_monitor;

   localparam int NCH  = 2;
   localparam int XLEN = 64;
   localparam int HD   = 4;

   logic                clock;
   logic                reset;
   logic [NCH-1:0]      commit_valid;
   logic [NCH*XLEN-1:0] commit_pc;
   logic                finish_req;
   logic                fail_req;
   logic [63:0]         max_cycles;
   logic [31:0]         hang_limit;
   logic [63:0]         dump_start;
   logic [63:0]         dump_len;
   logic [1:0]          state;
   logic [2:0]          reason;
   logic [63:0]         cycle_count;
   logic [63:0]         commit_total;
   logic                dump_en;
   logic                done;
`ifdef SIM_RUN_MONITOR_HISTORY_EN
   logic [1:0]          hist_idx;
   logic [XLEN-1:0]     hist_pc;
   logic [2:0]          hist_ch;
`endif

   sim_run_monitor #(.NCH(NCH), .XLEN(XLEN), .HIST_DEPTH(HD)) dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .finish_req   (finish_req),
      .fail_req     (fail_req),
      .max_cycles   (max_cycles),
      .hang_limit   (hang_limit),
      .dump_start   (dump_start),
      .dump_len     (dump_len),
      .state        (state),
      .reason       (reason),
      .cycle_count  (cycle_count),
      .commit_total (commit_total),
      .dump_en      (dump_en),
      .done         (done)
`ifdef SIM_RUN_MONITOR_HISTORY_EN
      ,
      .hist_idx     (hist_idx),
      .hist_pc      (hist_pc),
      .hist_ch      (hist_ch)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic [2:0]  rsn;
      logic [63:0] cyc;
      logic [63:0] tot;
      logic        dump;
      logic        dn;
      logic        hchk;
      logic [1:0]  hidx;
      logic [63:0] hpc;
      logic [2:0]  hch;
   } snap_t;

   typedef struct {
      logic [63:0] cyc;
      logic        dump;
   } dump_t;

   snap_t term_q[$];
   snap_t snap_q[$];
   dump_t dump_q[$];
   logic  snap_req = 1'b0;

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic snap_t mk(input string name, input logic [1:0] st, input logic [2:0] rsn,
                                input logic [63:0] cyc, input logic [63:0] tot,
                                input logic dump, input logic dn);
      snap_t s;
      s.name = name; s.st = st; s.rsn = rsn; s.cyc = cyc; s.tot = tot;
      s.dump = dump; s.dn = dn; s.hchk = 1'b0; s.hidx = '0; s.hpc = '0; s.hch = '0;
      return s;
   endfunction

   function automatic snap_t with_hist(input snap_t s, input logic [1:0] idx,
                                       input logic [63:0] pc, input logic [2:0] ch);
      snap_t r;
      r = s; r.hchk = 1'b1; r.hidx = idx; r.hpc = pc; r.hch = ch;
      return r;
   endfunction

   task automatic cmp(input snap_t s);
      check({s.name, "/state"},  64'(state),   64'(s.st));
      check({s.name, "/reason"}, 64'(reason),  64'(s.rsn));
      check({s.name, "/cycles"}, cycle_count,  s.cyc);
      check({s.name, "/commits"}, commit_total, s.tot);
      check({s.name, "/dump_en"}, 64'(dump_en), 64'(s.dump));
      check({s.name, "/done"},   64'(done),    64'(s.dn));
`ifdef SIM_RUN_MONITOR_HISTORY_EN
      if (s.hchk) begin
         check({s.name, "/hist_pc"}, hist_pc,       s.hpc);
         check({s.name, "/hist_ch"}, 64'(hist_ch),  64'(s.hch));
      end
`endif
   endtask

   // Monitor: terminations on done rising, snapshots on request, dump per cycle.
   initial begin
      logic  done_prev;
      snap_t s;
      dump_t d;
      done_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (done === 1'b1 && done_prev === 1'b0) begin
            if (term_q.size() > 0) begin
               s = term_q.pop_front();
               cmp(s);
            end else begin
               check("unexpected_done", 64'(done), 64'd0);
            end
         end
         done_prev = done;
         if (snap_req && snap_q.size() > 0) begin
            s = snap_q.pop_front();
            cmp(s);
         end
         if (dump_q.size() > 0) begin
            d = dump_q.pop_front();
            check("dump_cycle", cycle_count, d.cyc);
            check("dump_window", 64'(dump_en), 64'(d.dump));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic snap(input snap_t s);
`ifdef SIM_RUN_MONITOR_HISTORY_EN
      hist_idx = s.hidx;
`endif
      snap_q.push_back(s);
      snap_req = 1'b1;
      @(negedge clock);
      #1;
      snap_req = 1'b0;
   endtask

   task automatic wait_term(input string name, input int budget);
      int n;
      n = 0;
      while (term_q.size() != 0 && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      check({name, "/term_seen"}, 64'(term_q.size()), 64'd0);
      term_q.delete();
   endtask

   // Reset with the given configuration, then enter the first RUN cycle.
   task automatic start_run(input string name, input logic [63:0] mc, input logic [31:0] hl,
                            input logic [63:0] ds, input logic [63:0] dl);
      max_cycles = mc; hang_limit = hl; dump_start = ds; dump_len = dl;
      commit_valid = '0; finish_req = 1'b0; fail_req = 1'b0;
      reset = 1'b0;
      step(2);
      snap(mk({name, "_reset"}, 2'd0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0));
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      dump_t d;
      reset = 1'b0; commit_valid = '0; commit_pc = '0; finish_req = 1'b0; fail_req = 1'b0;
      max_cycles = '0; hang_limit = '0; dump_start = '0; dump_len = '0;
`ifdef SIM_RUN_MONITOR_HISTORY_EN
      hist_idx = '0;
`endif

      // Pass after 10 cycles of dual commits; later inputs ignored.
      start_run("t1", 64'd0, 32'd0, 64'd0, 64'd0);
      snap(mk("t1_first_run", 2'd1, 3'd0, 64'd1, 64'd0, 1'b1, 1'b0));
      commit_valid = 2'b11;
      step(10);
      commit_valid = 2'b00; finish_req = 1'b1;
      term_q.push_back(mk("t1_pass", 2'd2, 3'd4, 64'd12, 64'd20, 1'b0, 1'b1));
      step(1);
      finish_req = 1'b0;
      wait_term("t1", 4);
      commit_valid = 2'b11; fail_req = 1'b1;
      step(3);
      snap(mk("t1_frozen", 2'd2, 3'd4, 64'd12, 64'd20, 1'b0, 1'b1));
      commit_valid = 2'b00; fail_req = 1'b0;

      // Timeout at 100 with a bounded dump window 10..14.
      start_run("t2", 64'd100, 32'd0, 64'd10, 64'd5);
      for (int k = 1; k <= 101; k++) begin
         if (k <= 20) begin
            d.cyc = 64'(k); d.dump = (k >= 10 && k <= 14);
            dump_q.push_back(d);
         end
         if (k == 101) term_q.push_back(mk("t2_timeout", 2'd3, 3'd2, 64'd102, 64'd0, 1'b0, 1'b1));
         step(1);
      end
      wait_term("t2", 4);
      commit_valid = 2'b01;
      step(3);
      snap(mk("t2_frozen", 2'd3, 3'd2, 64'd102, 64'd0, 1'b0, 1'b1));
      commit_valid = 2'b00;

      // Hang: commit at cycle 3 then idle, fires at the end of cycle 8.
      start_run("t3", 64'd0, 32'd5, 64'd0, 64'd0);
      term_q.push_back(mk("t3_hang", 2'd3, 3'd3, 64'd9, 64'd1, 1'b0, 1'b1));
      for (int k = 1; k <= 8; k++) begin
         commit_valid = (k == 3) ? 2'b01 : 2'b00;
         step(1);
      end
      commit_valid = 2'b00;
      wait_term("t3", 4);

      // Commits at 3 and 7 keep the hang counter short; commit+finish counts.
      start_run("t3b", 64'd0, 32'd5, 64'd0, 64'd0);
      for (int k = 1; k <= 10; k++) begin
         commit_valid = (k == 3 || k == 7) ? 2'b01 : 2'b00;
         step(1);
      end
      commit_valid = 2'b00;
      snap(mk("t3b_no_hang", 2'd1, 3'd0, 64'd11, 64'd2, 1'b1, 1'b0));
      commit_valid = 2'b10; finish_req = 1'b1;
      term_q.push_back(mk("t3b_pass", 2'd2, 3'd4, 64'd12, 64'd3, 1'b0, 1'b1));
      step(1);
      commit_valid = 2'b00; finish_req = 1'b0;
      wait_term("t3b", 4);

      // fail_req beats finish_req.
      start_run("t4", 64'd0, 32'd0, 64'd0, 64'd0);
      step(3);
      fail_req = 1'b1; finish_req = 1'b1;
      term_q.push_back(mk("t4_prio_fail", 2'd3, 3'd1, 64'd5, 64'd0, 1'b0, 1'b1));
      step(1);
      fail_req = 1'b0; finish_req = 1'b0;
      wait_term("t4", 4);

      // Timeout and hang in the same cycle: timeout wins.
      start_run("t5", 64'd5, 32'd6, 64'd0, 64'd0);
      term_q.push_back(mk("t5_prio_timeout", 2'd3, 3'd2, 64'd7, 64'd0, 1'b0, 1'b1));
      wait_term("t5", 12);

      // Unbounded dump window from cycle 10 until PASS.
      start_run("t6", 64'd0, 32'd0, 64'd10, 64'd0);
      for (int k = 1; k <= 16; k++) begin
         d.cyc = 64'(k); d.dump = (k >= 10);
         dump_q.push_back(d);
         if (k == 16) begin
            finish_req = 1'b1;
            term_q.push_back(mk("t6_pass", 2'd2, 3'd4, 64'd17, 64'd0, 1'b0, 1'b1));
         end
         step(1);
      end
      finish_req = 1'b0;
      wait_term("t6", 4);

      // History ring contents, then reset mid-run.
      start_run("t7", 64'd0, 32'd0, 64'd0, 64'd0);
      for (int k = 0; k < 6; k++) begin
         commit_valid = 2'b10;
         commit_pc = {64'h8000_0000 + 64'(4 * k), 64'h0};
         step(1);
      end
      commit_valid = 2'b00;
      snap(with_hist(mk("t7_hist0", 2'd1, 3'd0, 64'd7, 64'd6, 1'b1, 1'b0), 2'd0, 64'h8000_0014, 3'd1));
      snap(with_hist(mk("t7_hist3", 2'd1, 3'd0, 64'd8, 64'd6, 1'b1, 1'b0), 2'd3, 64'h8000_0008, 3'd1));
      reset = 1'b0;
      step(1);
      snap(with_hist(mk("t7_reset", 2'd0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0), 2'd0, 64'h0, 3'd0));
      reset = 1'b1;
      step(1);
      snap(with_hist(mk("t7_rerun", 2'd1, 3'd0, 64'd1, 64'd0, 1'b1, 1'b0), 2'd0, 64'h0, 3'd0));

      step(2);
      check("snap_queue_drained", 64'(snap_q.size()), 64'd0);
      check("dump_queue_drained", 64'(dump_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
